// File: rtl/rf_pkg.sv
// Shared types and constants for the RV32E operand fetch slice.
// Register fields are 5 bits wide; the RV32E file has 16 entries.
package rf_pkg;

  localparam int BIT_WIDTH = 32;
  localparam int ADDR_W    = 5;
  localparam int RF_ADDR_W = 4;
  localparam int NUM_REGS  = 16;

  typedef enum logic [1:0] {
    IDLE,
    RD1,
    RD2,
    HOLD
  } fetch_state_t;

  function automatic logic is_illegal_reg(
    input logic [ADDR_W-1:0] addr
  );
    return addr[ADDR_W-1];
  endfunction

endpackage

// File: rtl/rf_operand_fetch_if.sv
// Request (control unit) and operand (execute) handshakes
// of the operand fetch block.
interface rf_operand_fetch_if #(
  parameter int BIT_WIDTH = 32,
  parameter int ADDR_W    = 5
);

  logic                 req_valid;
  logic                 req_ready;
  logic [ADDR_W-1:0]    rs1_addr;
  logic [ADDR_W-1:0]    rs2_addr;
  logic                 need_rs2;
  logic                 op_valid;
  logic                 op_ready;
  logic [BIT_WIDTH-1:0] rs1_data;
  logic [BIT_WIDTH-1:0] rs2_data;
  logic                 op_illegal;

  modport master (
    output req_valid,
    input  req_ready,
    output rs1_addr,
    output rs2_addr,
    output need_rs2,
    input  op_valid,
    output op_ready,
    input  rs1_data,
    input  rs2_data,
    input  op_illegal
  );

  modport slave (
    input  req_valid,
    output req_ready,
    input  rs1_addr,
    input  rs2_addr,
    input  need_rs2,
    output op_valid,
    input  op_ready,
    output rs1_data,
    output rs2_data,
    output op_illegal
  );

endinterface

// File: rtl/rf_bypass.sv
// Forward mux: zero for x0/illegal, snooped write data on a
// same-cycle hit, otherwise the register file read data.
module rf_bypass
  import rf_pkg::*;
#(
  parameter int BIT_WIDTH = rf_pkg::BIT_WIDTH
) (
  input  logic [ADDR_W-1:0]    addr,
  input  logic [BIT_WIDTH-1:0] rf_data,
  input  logic                 wb_en,
  input  logic [RF_ADDR_W-1:0] wb_reg,
  input  logic [BIT_WIDTH-1:0] wb_data,
  output logic [BIT_WIDTH-1:0] data
);

  logic zero;
  logic fwd;

  assign zero = is_illegal_reg(addr) ||
                (addr[RF_ADDR_W-1:0] == '0);
  assign fwd  = !zero && wb_en &&
                (wb_reg == addr[RF_ADDR_W-1:0]);

  always_comb begin
    data = rf_data;
    unique case (1'b1)
      zero:    data = '0;
      fwd:     data = wb_data;
      default: data = rf_data;
    endcase
  end

endmodule

// File: rtl/rf_operand_fetch.sv
// Sequences rs1/rs2 reads over the single RF read port and
// holds the operand pair, kept coherent with writeback, for execute.
module rf_operand_fetch
  import rf_pkg::*;
#(
  parameter int BIT_WIDTH = rf_pkg::BIT_WIDTH,
  parameter int ADDR_W    = rf_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rf_operand_fetch_if.slave    op_if,
  output logic [RF_ADDR_W-1:0] rf_read_reg,
  input  logic [BIT_WIDTH-1:0] rf_data_out,
  input  logic                 wb_write_en,
  input  logic [RF_ADDR_W-1:0] wb_write_reg,
  input  logic [BIT_WIDTH-1:0] wb_data_in
);

  fetch_state_t         state_q, state_d;
  logic [ADDR_W-1:0]    rs1_q, rs1_d;
  logic [ADDR_W-1:0]    rs2_q, rs2_d;
  logic                 need_q, need_d;
  logic [BIT_WIDTH-1:0] d1_q, d1_d;
  logic [BIT_WIDTH-1:0] d2_q, d2_d;
  logic                 vld_q, vld_d;
  logic                 ill_q, ill_d;

  logic [ADDR_W-1:0]    rd_addr;
  logic [BIT_WIDTH-1:0] byp;
  logic                 hit1;
  logic                 hit2;
  logic                 ill_any;

  assign rd_addr = (state_q == RD2) ? rs2_q : rs1_q;

  rf_bypass #(
    .BIT_WIDTH (BIT_WIDTH)
  ) u_bypass (
    .addr    (rd_addr),
    .rf_data (rf_data_out),
    .wb_en   (wb_write_en),
    .wb_reg  (wb_write_reg),
    .wb_data (wb_data_in),
    .data    (byp)
  );

  always_comb begin
    rf_read_reg = '0;
    unique case (state_q)
      RD1:     rf_read_reg = rs1_q[RF_ADDR_W-1:0];
      RD2:     rf_read_reg = rs2_q[RF_ADDR_W-1:0];
      default: rf_read_reg = '0;
    endcase
  end

  assign op_if.req_ready  = (state_q == IDLE);
  assign op_if.op_valid   = vld_q;
  assign op_if.rs1_data   = d1_q;
  assign op_if.rs2_data   = d2_q;
  assign op_if.op_illegal = ill_q;

  // Writes landing while operands wait must reach the held copies
  assign hit1 = wb_write_en && !is_illegal_reg(rs1_q) &&
                (rs1_q[RF_ADDR_W-1:0] != '0) &&
                (wb_write_reg == rs1_q[RF_ADDR_W-1:0]);
  assign hit2 = wb_write_en && need_q &&
                !is_illegal_reg(rs2_q) &&
                (rs2_q[RF_ADDR_W-1:0] != '0) &&
                (wb_write_reg == rs2_q[RF_ADDR_W-1:0]);

  assign ill_any = is_illegal_reg(rs1_q) ||
                   (need_q && is_illegal_reg(rs2_q));

  always_comb begin
    state_d = state_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    need_d  = need_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    vld_d   = vld_q;
    ill_d   = ill_q;
    unique case (state_q)
      IDLE: begin
        if (op_if.req_valid) begin
          rs1_d   = op_if.rs1_addr;
          rs2_d   = op_if.rs2_addr;
          need_d  = op_if.need_rs2;
          if (!op_if.need_rs2) d2_d = '0;
          state_d = RD1;
        end
      end
      RD1: begin
        d1_d = byp;
        if (need_q) begin
          state_d = RD2;
        end else begin
          state_d = HOLD;
          vld_d   = 1'b1;
          ill_d   = ill_any;
        end
      end
      RD2: begin
        d2_d    = byp;
        state_d = HOLD;
        vld_d   = 1'b1;
        ill_d   = ill_any;
      end
      HOLD: begin
        if (op_if.op_ready) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          ill_d   = 1'b0;
        end else begin
          if (hit1) d1_d = wb_data_in;
          if (hit2) d2_d = wb_data_in;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      need_q  <= 1'b0;
      d1_q    <= '0;
      d2_q    <= '0;
      vld_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      need_q  <= need_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      vld_q   <= vld_d;
      ill_q   <= ill_d;
    end
  end

endmodule

// File: tb/tb_rf_operand_fetch.sv
// Directed bench for rf_operand_fetch with a behavioural
// 16-entry register file on the read port.
module tb_rf_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  rf_read_reg;
  logic [31:0] rf_data_out;
  logic        wb_write_en = 1'b0;
  logic [3:0]  wb_write_reg = '0;
  logic [31:0] wb_data_in = '0;
  logic [31:0] rf [16];
  logic [3:0]  reads [$];
  int          lat;
  int          nvec = 0;
  int          nerr = 0;

  rf_operand_fetch_if #(.BIT_WIDTH(32), .ADDR_W(5)) bus ();

  rf_operand_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op_if        (bus.slave),
    .rf_read_reg  (rf_read_reg),
    .rf_data_out  (rf_data_out),
    .wb_write_en  (wb_write_en),
    .wb_write_reg (wb_write_reg),
    .wb_data_in   (wb_data_in)
  );

  assign rf_data_out = rf[rf_read_reg];

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic start_req(input logic [4:0] a1,
                           input logic [4:0] a2,
                           input logic nd);
    @(negedge clk);
    nvec++;
    if (bus.req_ready !== 1'b1) begin
      nerr++;
      $display("FAIL req_ready_idle got %b want 1", bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.rs1_addr  = a1;
    bus.rs2_addr  = a2;
    bus.need_rs2  = nd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rs1_addr  = ~a1;
    bus.rs2_addr  = ~a2;
    bus.need_rs2  = ~nd;
    nvec++;
    if (bus.req_ready !== 1'b0) begin
      nerr++;
      $display("FAIL req_ready_busy got %b want 0", bus.req_ready);
    end
  endtask

  task automatic wait_valid();
    lat = 1;
    reads.delete();
    while (bus.op_valid !== 1'b1 && lat < 8) begin
      reads.push_back(rf_read_reg);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handoff();
    bus.op_ready = 1'b1;
    @(negedge clk);
    bus.op_ready = 1'b0;
    nvec++;
    if (bus.op_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      nerr++;
      $display("FAIL handoff got valid=%b ready=%b want 0/1",
               bus.op_valid, bus.req_ready);
    end
  endtask

  task automatic test_reset();
    #2;
    nvec++;
    if (bus.req_ready !== 1'b1 || bus.op_valid !== 1'b0 ||
        bus.op_illegal !== 1'b0) begin
      nerr++;
      $display("FAIL reset_ctrl got rdy=%b vld=%b ill=%b want 1/0/0",
               bus.req_ready, bus.op_valid, bus.op_illegal);
    end
    nvec++;
    if (bus.rs1_data !== 32'h0 || bus.rs2_data !== 32'h0 ||
        rf_read_reg !== 4'h0) begin
      nerr++;
      $display("FAIL reset_data got %h %h %h want 0/0/0",
               bus.rs1_data, bus.rs2_data, rf_read_reg);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_two_reads();
    start_req(5'd5, 5'd6, 1'b1);
    wait_valid();
    nvec++;
    if (lat !== 3) begin
      nerr++;
      $display("FAIL two_lat got %0d want 3", lat);
    end
    nvec++;
    if (reads.size() !== 2 || reads[0] !== 4'd5 || reads[1] !== 4'd6) begin
      nerr++;
      $display("FAIL two_reads got n=%0d %h %h want 2 5 6",
               reads.size(), reads[0], reads[1]);
    end
    nvec++;
    if (bus.rs1_data !== 32'h0000_1234 || bus.rs2_data !== 32'hDEAD_BEEF ||
        bus.op_illegal !== 1'b0) begin
      nerr++;
      $display("FAIL two_data got %h %h ill=%b want 00001234 deadbeef 0",
               bus.rs1_data, bus.rs2_data, bus.op_illegal);
    end
    handoff();
  endtask

  task automatic test_rs1_only();
    start_req(5'd7, 5'd6, 1'b0);
    wait_valid();
    nvec++;
    if (lat !== 2 || reads.size() !== 1 || reads[0] !== 4'd7) begin
      nerr++;
      $display("FAIL one_seq got lat=%0d n=%0d r=%h want 2 1 7",
               lat, reads.size(), reads[0]);
    end
    nvec++;
    if (bus.rs1_data !== 32'hA5A5_A5A5 || bus.rs2_data !== 32'h0) begin
      nerr++;
      $display("FAIL one_data got %h %h want a5a5a5a5 0",
               bus.rs1_data, bus.rs2_data);
    end
    handoff();
  endtask

  task automatic test_forward();
    start_req(5'd3, 5'd0, 1'b0);
    wb_write_en  = 1'b1;
    wb_write_reg = 4'd3;
    wb_data_in   = 32'h55;
    @(negedge clk);
    wb_write_en = 1'b0;
    rf[3] = 32'h55;
    nvec++;
    if (bus.op_valid !== 1'b1 || bus.rs1_data !== 32'h55) begin
      nerr++;
      $display("FAIL forward got vld=%b %h want 1 00000055",
               bus.op_valid, bus.rs1_data);
    end
    handoff();
  endtask

  task automatic test_hold_coherency();
    start_req(5'd4, 5'd9, 1'b1);
    wait_valid();
    nvec++;
    if (bus.rs2_data !== 32'h11 || bus.rs1_data !== 32'h44) begin
      nerr++;
      $display("FAIL coh_pre got %h %h want 44 11",
               bus.rs1_data, bus.rs2_data);
    end
    wb_write_en  = 1'b1;
    wb_write_reg = 4'd9;
    wb_data_in   = 32'h77;
    @(negedge clk);
    rf[9] = 32'h77;
    wb_write_en = 1'b0;
    nvec++;
    if (bus.rs2_data !== 32'h77 || bus.rs1_data !== 32'h44 ||
        bus.op_valid !== 1'b1) begin
      nerr++;
      $display("FAIL coh_upd got %h %h vld=%b want 44 77 1",
               bus.rs1_data, bus.rs2_data, bus.op_valid);
    end
    bus.op_ready = 1'b1;
    wb_write_en  = 1'b1;
    wb_write_reg = 4'd9;
    wb_data_in   = 32'h88;
    nvec++;
    if (bus.rs2_data !== 32'h77) begin
      nerr++;
      $display("FAIL coh_take got %h want 77", bus.rs2_data);
    end
    @(negedge clk);
    rf[9] = 32'h88;
    wb_write_en  = 1'b0;
    bus.op_ready = 1'b0;
    nvec++;
    if (bus.op_valid !== 1'b0 || bus.req_ready !== 1'b1 ||
        bus.rs2_data !== 32'h77) begin
      nerr++;
      $display("FAIL coh_idle got vld=%b rdy=%b %h want 0 1 77",
               bus.op_valid, bus.req_ready, bus.rs2_data);
    end
    start_req(5'd10, 5'd10, 1'b1);
    wait_valid();
    wb_write_en  = 1'b1;
    wb_write_reg = 4'd10;
    wb_data_in   = 32'hBB;
    @(negedge clk);
    rf[10] = 32'hBB;
    wb_write_reg = 4'd4;
    wb_data_in   = 32'hCC;
    @(negedge clk);
    rf[4] = 32'hCC;
    wb_write_en = 1'b0;
    nvec++;
    if (bus.rs1_data !== 32'hBB || bus.rs2_data !== 32'hBB) begin
      nerr++;
      $display("FAIL coh_same got %h %h want bb bb",
               bus.rs1_data, bus.rs2_data);
    end
    handoff();
  endtask

  task automatic test_x0_illegal();
    start_req(5'd0, 5'd0, 1'b0);
    wb_write_en  = 1'b1;
    wb_write_reg = 4'd0;
    wb_data_in   = 32'hFF;
    @(negedge clk);
    nvec++;
    if (bus.op_valid !== 1'b1 || bus.rs1_data !== 32'h0 ||
        bus.op_illegal !== 1'b0) begin
      nerr++;
      $display("FAIL x0_read got vld=%b %h ill=%b want 1 0 0",
               bus.op_valid, bus.rs1_data, bus.op_illegal);
    end
    @(negedge clk);
    wb_write_en = 1'b0;
    nvec++;
    if (bus.rs1_data !== 32'h0) begin
      nerr++;
      $display("FAIL x0_hold got %h want 0", bus.rs1_data);
    end
    handoff();
    start_req(5'd2, 5'h12, 1'b1);
    wait_valid();
    nvec++;
    if (lat !== 3 || reads[1] !== 4'd2 || bus.op_illegal !== 1'b1) begin
      nerr++;
      $display("FAIL ill_rs2 got lat=%0d r=%h ill=%b want 3 2 1",
               lat, reads[1], bus.op_illegal);
    end
    nvec++;
    if (bus.rs1_data !== 32'h22 || bus.rs2_data !== 32'h0) begin
      nerr++;
      $display("FAIL ill_rs2_data got %h %h want 22 0",
               bus.rs1_data, bus.rs2_data);
    end
    handoff();
    start_req(5'h11, 5'd2, 1'b0);
    wait_valid();
    nvec++;
    if (lat !== 2 || bus.op_illegal !== 1'b1 || bus.rs1_data !== 32'h0) begin
      nerr++;
      $display("FAIL ill_rs1 got lat=%0d ill=%b %h want 2 1 0",
               lat, bus.op_illegal, bus.rs1_data);
    end
    handoff();
    start_req(5'd1, 5'h13, 1'b0);
    wait_valid();
    nvec++;
    if (bus.op_illegal !== 1'b0 || bus.rs1_data !== 32'h1111 ||
        bus.rs2_data !== 32'h0) begin
      nerr++;
      $display("FAIL ill_unused got ill=%b %h %h want 0 1111 0",
               bus.op_illegal, bus.rs1_data, bus.rs2_data);
    end
    handoff();
  endtask

  task automatic test_reset_mid();
    start_req(5'd5, 5'd6, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    nvec++;
    if (bus.op_valid !== 1'b0 || bus.rs1_data !== 32'h0 ||
        bus.rs2_data !== 32'h0 || rf_read_reg !== 4'h0) begin
      nerr++;
      $display("FAIL rst_mid got vld=%b %h %h rd=%h want 0 0 0 0",
               bus.op_valid, bus.rs1_data, bus.rs2_data, rf_read_reg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    nvec++;
    if (bus.req_ready !== 1'b1) begin
      nerr++;
      $display("FAIL rst_ready got %b want 1", bus.req_ready);
    end
    start_req(5'd5, 5'd6, 1'b1);
    wait_valid();
    nvec++;
    if (lat !== 3 || bus.rs1_data !== 32'h0000_1234 ||
        bus.rs2_data !== 32'hDEAD_BEEF) begin
      nerr++;
      $display("FAIL rst_next got lat=%0d %h %h want 3 1234 deadbeef",
               lat, bus.rs1_data, bus.rs2_data);
    end
    handoff();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 32'h0;
    rf[1]  = 32'h1111;
    rf[2]  = 32'h22;
    rf[3]  = 32'h1;
    rf[4]  = 32'h44;
    rf[5]  = 32'h0000_1234;
    rf[6]  = 32'hDEAD_BEEF;
    rf[7]  = 32'hA5A5_A5A5;
    rf[9]  = 32'h11;
    rf[10] = 32'hA;
    bus.req_valid = 1'b0;
    bus.rs1_addr  = '0;
    bus.rs2_addr  = '0;
    bus.need_rs2  = 1'b0;
    bus.op_ready  = 1'b0;
    test_reset();
    test_two_reads();
    test_rs1_only();
    test_forward();
    test_hold_coherency();
    test_x0_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
